// File: rtl/traffic_conflict_monitor.sv
// Safety gate between the traffic light controller and the lamp drivers.
// Legal commands pass with one cycle of latency; any violation latches a fault and flashes red.
module traffic_conflict_monitor #(
    parameter int STARTUP_CYCLES = 4,
    parameter int MIN_YELLOW     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] light_M1_in,
    input  logic [2:0] light_S_in,
    input  logic [2:0] light_MT_in,
    input  logic [2:0] light_M2_in,
    input  logic       clr_fault,
    output logic [2:0] light_M1,
    output logic [2:0] light_S,
    output logic [2:0] light_MT,
    output logic [2:0] light_M2,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [1:0] fault_lane
);

    localparam logic [2:0] RED  = 3'b100;
    localparam logic [2:0] YEL  = 3'b010;
    localparam logic [2:0] GRN  = 3'b001;
    localparam logic [2:0] DARK = 3'b000;

    localparam int              CNT_W      = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(STARTUP_CYCLES - 1);
    localparam logic [3:0]      MIN_Y      = 4'(MIN_YELLOW);

    localparam logic [2:0] CODE_NONE  = 3'd0;
    localparam logic [2:0] CODE_ENC   = 3'd1;
    localparam logic [2:0] CODE_CONF  = 3'd2;
    localparam logic [2:0] CODE_TRANS = 3'd3;
    localparam logic [2:0] CODE_SHORT = 3'd4;

    typedef enum logic [1:0] {
        START   = 2'd0,
        MONITOR = 2'd1,
        FAULT   = 2'd2
    } state_t;

    function automatic logic is_legal(input logic [2:0] v);
        return (v == RED) || (v == YEL) || (v == GRN);
    endfunction

    function automatic logic [3:0] ycnt_sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    state_t           state, state_nxt;
    logic [CNT_W-1:0] start_cnt, start_cnt_nxt;
    logic             fault_nxt;
    logic [2:0]       fault_code_nxt;
    logic [1:0]       fault_lane_nxt;

    logic [2:0] lane_in  [4];
    logic [2:0] prev     [4];
    logic [3:0] ycnt     [4];
    logic [2:0] lamp_p1  [4];
    logic [2:0] lamp_nxt [4];

    logic [3:0] bad_enc, bad_trans, short_y, is_grn;
    logic       chk_fail;
    logic [2:0] chk_code;
    logic [1:0] chk_lane;

    assign lane_in[0] = light_M1_in;
    assign lane_in[1] = light_S_in;
    assign lane_in[2] = light_MT_in;
    assign lane_in[3] = light_M2_in;

    // Stage p0: combinational checks of current inputs against the previous sample
    always_comb begin
        bad_enc   = '0;
        bad_trans = '0;
        short_y   = '0;
        is_grn    = '0;
        for (int i = 0; i < 4; i++) begin
            bad_enc[i]   = !is_legal(lane_in[i]);
            is_grn[i]    = (lane_in[i] == GRN);
            bad_trans[i] = ((prev[i] == RED) && (lane_in[i] == YEL)) ||
                           ((prev[i] == GRN) && (lane_in[i] == RED)) ||
                           ((prev[i] == YEL) && (lane_in[i] == GRN));
            short_y[i]   = (prev[i] == YEL) && (lane_in[i] == RED) && (ycnt[i] < MIN_Y);
        end
    end

    // Lowest code wins, then lowest lane: apply in reverse priority so the winner is written last.
    always_comb begin
        chk_fail = 1'b0;
        chk_code = CODE_NONE;
        chk_lane = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (short_y[i]) begin
                chk_fail = 1'b1;
                chk_code = CODE_SHORT;
                chk_lane = 2'(i);
            end
        end
        for (int i = 3; i >= 0; i--) begin
            if (bad_trans[i]) begin
                chk_fail = 1'b1;
                chk_code = CODE_TRANS;
                chk_lane = 2'(i);
            end
        end
        if (is_grn[2] && is_grn[3]) begin
            chk_fail = 1'b1;
            chk_code = CODE_CONF;
            chk_lane = 2'd3;
        end
        if (is_grn[1] && is_grn[3]) begin
            chk_fail = 1'b1;
            chk_code = CODE_CONF;
            chk_lane = 2'd3;
        end
        if (is_grn[1] && is_grn[2]) begin
            chk_fail = 1'b1;
            chk_code = CODE_CONF;
            chk_lane = 2'd2;
        end
        if (is_grn[0] && is_grn[1]) begin
            chk_fail = 1'b1;
            chk_code = CODE_CONF;
            chk_lane = 2'd1;
        end
        for (int i = 3; i >= 0; i--) begin
            if (bad_enc[i]) begin
                chk_fail = 1'b1;
                chk_code = CODE_ENC;
                chk_lane = 2'(i);
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        start_cnt_nxt  = start_cnt;
        fault_nxt      = fault;
        fault_code_nxt = fault_code;
        fault_lane_nxt = fault_lane;
        lamp_nxt       = lamp_p1;
        case (state)
            START: begin
                for (int i = 0; i < 4; i++) lamp_nxt[i] = RED;
                if (start_cnt == START_LAST) begin
                    state_nxt     = MONITOR;
                    start_cnt_nxt = '0;
                end else begin
                    start_cnt_nxt = start_cnt + 1'b1;
                end
            end
            MONITOR: begin
                if (chk_fail) begin
                    state_nxt      = FAULT;
                    fault_nxt      = 1'b1;
                    fault_code_nxt = chk_code;
                    fault_lane_nxt = chk_lane;
                    for (int i = 0; i < 4; i++) lamp_nxt[i] = RED;
                end else begin
                    lamp_nxt = lane_in;
                end
            end
            FAULT: begin
                if (clr_fault) begin
                    state_nxt      = START;
                    start_cnt_nxt  = '0;
                    fault_nxt      = 1'b0;
                    fault_code_nxt = CODE_NONE;
                    fault_lane_nxt = 2'd0;
                    for (int i = 0; i < 4; i++) lamp_nxt[i] = RED;
                end else begin
                    // All lanes flash in lockstep, keyed off lane 0.
                    for (int i = 0; i < 4; i++) lamp_nxt[i] = (lamp_p1[0] == RED) ? DARK : RED;
                end
            end
            default: begin
                state_nxt     = START;
                start_cnt_nxt = '0;
                for (int i = 0; i < 4; i++) lamp_nxt[i] = RED;
            end
        endcase
    end

    // Stage p1: registered lamp drive, fault status and per-lane history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= START;
            start_cnt  <= '0;
            fault      <= 1'b0;
            fault_code <= CODE_NONE;
            fault_lane <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                lamp_p1[i] <= RED;
                prev[i]    <= RED;
                ycnt[i]    <= 4'd0;
            end
        end else begin
            state      <= state_nxt;
            start_cnt  <= start_cnt_nxt;
            fault      <= fault_nxt;
            fault_code <= fault_code_nxt;
            fault_lane <= fault_lane_nxt;
            for (int i = 0; i < 4; i++) begin
                lamp_p1[i] <= lamp_nxt[i];
                prev[i]    <= lane_in[i];
                ycnt[i]    <= (lane_in[i] == YEL) ? ycnt_sat_inc(ycnt[i]) : 4'd0;
            end
        end
    end

    assign light_M1 = lamp_p1[0];
    assign light_S  = lamp_p1[1];
    assign light_MT = lamp_p1[2];
    assign light_M2 = lamp_p1[3];

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Directed and randomized bench for traffic_conflict_monitor against a behavioural model.
module tb_traffic_conflict_monitor;

    localparam int STARTUP_CYCLES = 4;
    localparam int MIN_YELLOW     = 3;
    localparam logic [2:0] R  = 3'b100;
    localparam logic [2:0] Y  = 3'b010;
    localparam logic [2:0] G  = 3'b001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] in_m1 = R, in_s = R, in_mt = R, in_m2 = R;
    logic       clr = 1'b0;
    logic [2:0] light_M1, light_S, light_MT, light_M2;
    logic       fault;
    logic [2:0] fault_code;
    logic [1:0] fault_lane;

    traffic_conflict_monitor #(
        .STARTUP_CYCLES(STARTUP_CYCLES),
        .MIN_YELLOW    (MIN_YELLOW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .light_M1_in(in_m1),
        .light_S_in (in_s),
        .light_MT_in(in_mt),
        .light_M2_in(in_m2),
        .clr_fault  (clr),
        .light_M1   (light_M1),
        .light_S    (light_S),
        .light_MT   (light_MT),
        .light_M2   (light_M2),
        .fault      (fault),
        .fault_code (fault_code),
        .fault_lane (fault_lane)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model: startup countdown, fault latch, flashing phase, per-lane history.
    logic [2:0] m_in   [4];
    logic [2:0] m_out  [4];
    logic [2:0] m_prev [4];
    int         m_ycnt [4];
    int         m_remain;
    logic       m_fault;
    logic [2:0] m_code;
    logic [1:0] m_lane;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_out[i]  = R;
            m_prev[i] = R;
            m_ycnt[i] = 0;
        end
        m_remain = STARTUP_CYCLES;
        m_fault  = 1'b0;
        m_code   = 3'd0;
        m_lane   = 2'd0;
    endtask

    task automatic find_violation(output logic [2:0] code, output logic [1:0] lane);
        int pa[4];
        int pb[4];
        pa = '{0, 1, 1, 2};
        pb = '{1, 2, 3, 3};
        code = 3'd0;
        lane = 2'd0;
        for (int i = 0; i < 4 && code == 3'd0; i++)
            if (!(m_in[i] inside {R, Y, G})) begin code = 3'd1; lane = 2'(i); end
        for (int k = 0; k < 4 && code == 3'd0; k++)
            if (m_in[pa[k]] == G && m_in[pb[k]] == G) begin code = 3'd2; lane = 2'(pb[k]); end
        for (int i = 0; i < 4 && code == 3'd0; i++)
            if ((m_prev[i] == R && m_in[i] == Y) || (m_prev[i] == G && m_in[i] == R) ||
                (m_prev[i] == Y && m_in[i] == G)) begin code = 3'd3; lane = 2'(i); end
        for (int i = 0; i < 4 && code == 3'd0; i++)
            if (m_prev[i] == Y && m_in[i] == R && m_ycnt[i] < MIN_YELLOW) begin
                code = 3'd4; lane = 2'(i);
            end
    endtask

    task automatic model_edge(input logic clr_v);
        logic [2:0] c;
        logic [1:0] l;
        logic [2:0] f;
        if (m_fault) begin
            if (clr_v) begin
                m_fault = 1'b0; m_code = 3'd0; m_lane = 2'd0;
                m_remain = STARTUP_CYCLES;
                for (int i = 0; i < 4; i++) m_out[i] = R;
            end else begin
                f = (m_out[0] == R) ? 3'b000 : R;
                for (int i = 0; i < 4; i++) m_out[i] = f;
            end
        end else if (m_remain > 0) begin
            m_remain--;
            for (int i = 0; i < 4; i++) m_out[i] = R;
        end else begin
            find_violation(c, l);
            if (c != 3'd0) begin
                m_fault = 1'b1; m_code = c; m_lane = l;
                for (int i = 0; i < 4; i++) m_out[i] = R;
            end else begin
                for (int i = 0; i < 4; i++) m_out[i] = m_in[i];
            end
        end
        for (int i = 0; i < 4; i++) begin
            m_ycnt[i] = (m_in[i] == Y) ? ((m_ycnt[i] < 15) ? m_ycnt[i] + 1 : 15) : 0;
            m_prev[i] = m_in[i];
        end
    endtask

    task automatic step(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                        input logic [2:0] d, input logic clr_v, input string tag);
        in_m1 = a; in_s = b; in_mt = c; in_m2 = d; clr = clr_v;
        m_in[0] = a; m_in[1] = b; m_in[2] = c; m_in[3] = d;
        model_edge(clr_v);
        @(posedge clk);
        #1;
        check({tag, ":lamps"}, {light_M1, light_S, light_MT, light_M2},
              {m_out[0], m_out[1], m_out[2], m_out[3]});
        check({tag, ":status"}, {fault, fault_code, fault_lane}, {m_fault, m_code, m_lane});
    endtask

    logic [2:0] gen [4];
    int         r;

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        check("reset_lamps", {light_M1, light_S, light_MT, light_M2}, {R, R, R, R});
        check("reset_status", {fault, fault_code, fault_lane}, 6'd0);
        rst = 1'b0;

        repeat (STARTUP_CYCLES) step(R, R, R, R, 1'b0, "startup");
        step(G, R, R, G, 1'b0, "legal_pass");
        check("legal_pass_const", {light_M1, light_S, light_MT, light_M2}, {G, R, R, G});
        step(G, R, R, G, 1'b1, "clr_in_monitor");
        check("clr_in_monitor_fault", fault, 1'b0);

        step(G, G, R, G, 1'b0, "conflict");
        check("conflict_const", {fault, fault_code, fault_lane, light_S}, {1'b1, 3'd2, 2'd1, R});
        step(G, G, R, G, 1'b0, "flash0");
        check("flash_dark", {light_M1, light_S, light_MT, light_M2}, 12'd0);
        repeat (2) step(G, G, R, G, 1'b0, "flash");

        step(R, R, R, R, 1'b1, "clear");
        check("clear_const", fault, 1'b0);
        repeat (STARTUP_CYCLES) step(R, R, R, R, 1'b0, "restart");
        step(G, R, R, R, 1'b0, "sy_green");
        step(Y, R, R, R, 1'b0, "sy_y1");
        step(Y, R, R, R, 1'b0, "sy_y2");
        step(R, R, R, R, 1'b0, "short_yellow");
        check("short_yellow_const", {fault, fault_code, fault_lane}, {1'b1, 3'd4, 2'd0});

        step(R, R, R, R, 1'b1, "clear2");
        repeat (STARTUP_CYCLES) step(R, R, R, R, 1'b0, "restart2");
        step(G, R, R, R, 1'b0, "ly_green");
        repeat (MIN_YELLOW) step(Y, R, R, R, 1'b0, "ly_yellow");
        step(R, R, R, R, 1'b0, "long_yellow");
        check("long_yellow_const", {fault, light_M1}, {1'b0, R});

        step(R, R, R, G, 1'b0, "m2_green");
        step(R, 3'b011, R, R, 1'b0, "priority");
        check("priority_const", {fault, fault_code, fault_lane}, {1'b1, 3'd1, 2'd1});
        step(R, R, R, R, 1'b0, "flash_before_rst");

        #3;
        rst = 1'b1;
        #1;
        check("async_rst_lamps", {light_M1, light_S, light_MT, light_M2}, {R, R, R, R});
        check("async_rst_status", {fault, fault_code, fault_lane}, 6'd0);
        model_reset();
        rst = 1'b0;

        for (int i = 0; i < 4; i++) gen[i] = R;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++) begin
                r = $urandom_range(0, 99);
                if (r < 3) gen[i] = 3'($urandom_range(0, 7));
                else if (r < 35) begin
                    case (gen[i])
                        R:       gen[i] = G;
                        G:       gen[i] = Y;
                        default: gen[i] = R;
                    endcase
                end
            end
            step(gen[0], gen[1], gen[2], gen[3], ($urandom_range(0, 3) == 0), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
